i2c_cmd_arbiter: RTL

//  Shares the single I2C_Controller (codec config bus, WM8731 at 8'h34) between NREQ command sources.

---
 rtl/i2c_arb_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/i2c_cmd_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the codec-configuration I2C command arbiter.
// Commands are {slave_addr, sub_addr, data}; the helpers slice or build them.
package i2c_arb_pkg;

    localparam int unsigned CMD_W      = 24;
    localparam logic [7:0]  CODEC_ADDR = 8'h34;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_END,
        RELEASE,
        GAP
    } state_t;

    function automatic logic [7:0] cmd_slave(input logic [CMD_W-1:0] cmd);
        return cmd[23:16];
    endfunction

    function automatic logic [7:0] cmd_sub(input logic [CMD_W-1:0] cmd);
        return cmd[15:8];
    endfunction

    function automatic logic [7:0] cmd_data(input logic [CMD_W-1:0] cmd);
        return cmd[7:0];
    endfunction

    function automatic logic [CMD_W-1:0] make_codec_cmd(input logic [7:0] sub, input logic [7:0] data);
        return {CODEC_ADDR, sub, data};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Produces a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    int unsigned pos;
    logic        found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = (32'(ptr) + i) % NREQ;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C_Controller between NREQ command sources: round-robin grant,
// GO/DATA sequencing, NACK retry, timeout and enforced bus-free gap.
module i2c_cmd_arbiter #(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned CMD_W     = 24,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned GAP_CYC   = 2500,
    parameter int unsigned TMO_CYC   = 2000000
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [NREQ-1:0]       iREQ,
    input  logic [NREQ*CMD_W-1:0] iCMD,
    output logic [NREQ-1:0]       oGNT,
    output logic [NREQ-1:0]       oDONE,
    output logic [NREQ-1:0]       oERR,
    output logic [CMD_W-1:0]      oI2C_DATA,
    output logic                  oI2C_GO,
    input  logic                  iI2C_END,
    input  logic                  iI2C_ACK,
    output logic                  oBUSY
);
    import i2c_arb_pkg::*;

    localparam int unsigned IDX_W   = $clog2(NREQ);
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);
    localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);

    state_t             state;
    logic               end_meta, end_s, end_prev;
    logic               ack_meta, ack_s;
    logic               end_rise;
    logic [IDX_W-1:0]   ptr, idx, arb_idx;
    logic [NREQ-1:0]    arb_gnt;
    logic [CMD_W-1:0]   cmd_sel;
    logic [RETRY_W-1:0] retry;
    logic               retry_pend;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    // END/ACK come from the controller's slow clock; both get the same depth so ACK is valid at the END edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            end_meta <= 1'b0;
            end_s    <= 1'b0;
            end_prev <= 1'b0;
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            end_meta <= iI2C_END;
            end_s    <= end_meta;
            end_prev <= end_s;
            ack_meta <= iI2C_ACK;
            ack_s    <= ack_meta;
        end
    end

    assign end_rise = end_s & ~end_prev;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req (iREQ),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        cmd_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_idx == IDX_W'(i)) cmd_sel = iCMD[i*CMD_W +: CMD_W];
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            retry      <= '0;
            retry_pend <= 1'b0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            oGNT       <= '0;
            oDONE      <= '0;
            oERR       <= '0;
            oI2C_DATA  <= '0;
            oI2C_GO    <= 1'b0;
            oBUSY      <= 1'b0;
        end else begin
            oDONE <= '0;
            oERR  <= '0;
            case (state)
                IDLE: begin
                    if (|iREQ) begin
                        idx        <= arb_idx;
                        oI2C_DATA  <= cmd_sel;
                        oGNT       <= arb_gnt;
                        retry      <= '0;
                        retry_pend <= 1'b0;
                        oBUSY      <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    oI2C_GO <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= WAIT_END;
                end
                WAIT_END: begin
                    if (tmo_cnt != TMO_W'(TMO_CYC)) tmo_cnt <= tmo_cnt + 1'b1;
                    // oGNT is one-hot on idx, so it doubles as the per-source pulse mask.
                    if (end_rise) begin
                        oI2C_GO <= 1'b0;
                        state   <= RELEASE;
                        if (!ack_s) begin
                            oDONE <= oGNT;
                        end else if (retry < RETRY_W'(MAX_RETRY)) begin
                            retry      <= retry + 1'b1;
                            retry_pend <= 1'b1;
                        end else begin
                            oERR <= oGNT;
                        end
                    end else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                        oI2C_GO <= 1'b0;
                        oERR    <= oGNT;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!end_s) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        gap_cnt <= GAP_W'(GAP_CYC);
                        if (retry_pend) begin
                            retry_pend <= 1'b0;
                            state      <= ISSUE;
                        end else begin
                            oGNT  <= '0;
                            ptr   <= (idx == IDX_W'(NREQ - 1)) ? '0 : idx + 1'b1;
                            oBUSY <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
